mm_result_collector: RTL

- Sits directly downstream of the parallel matrix-multiply datapath.
- Captures the per-column result writes (data, row address, write-enable) as each column's multiply core retires them. The columns retire out of step with each other.
- Reassembles the results into complete output rows and streams them out in ascending row order over a valid/ready interface.
- Tracks per-slot fill state and flags illegal writes.

---
 rtl/mm_result_collector.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mm_result_collector.sv
// Collects per-column matrix-multiply results as the column cores retire them,
// rebuilds full rows and streams them out in ascending row order.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | no matrix in flight; any column write is illegal
//   COLLECT  | accepting column writes, draining complete rows in order
//   DONE     | last row accepted; one-cycle done pulse, then IDLE
module mm_result_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_NUM    = 32,
    parameter int COL_NUM    = 32,
    localparam int SUM_WIDTH      = 4 * DATA_WIDTH,
    localparam int ROW_ADDR_WIDTH = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [SUM_WIDTH*COL_NUM-1:0]      row_data_in,
    input  logic [ROW_ADDR_WIDTH*COL_NUM-1:0] row_wraddr,
    input  logic [COL_NUM-1:0]                row_wr_en,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [SUM_WIDTH*COL_NUM-1:0]      out_data,
    output logic [ROW_ADDR_WIDTH-1:0]         out_row_addr,
    output logic                              out_last,
    output logic                              busy,
    output logic                              done,
    output logic                              wr_err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ROW = ROW_ADDR_WIDTH'(ROW_NUM - 1);

    logic [1:0]                state;
    logic [ROW_ADDR_WIDTH-1:0] rd_row;
    logic [COL_NUM-1:0]        fill [ROW_NUM];
    logic [SUM_WIDTH-1:0]      mem  [ROW_NUM][COL_NUM];

    logic [ROW_ADDR_WIDTH-1:0] wa [COL_NUM];
    logic [COL_NUM-1:0]        in_range;
    logic [COL_NUM-1:0]        wr_legal;
    logic [COL_NUM-1:0]        wr_bad;
    logic                      accept;

    // A write is legal only into an empty slot of an in-range row while collecting.
    // Writes coinciding with start are silently discarded.
    always_comb begin
        in_range = '0;
        wr_legal = '0;
        wr_bad   = '0;
        for (int c = 0; c < COL_NUM; c++) begin
            wa[c]       = row_wraddr[c*ROW_ADDR_WIDTH +: ROW_ADDR_WIDTH];
            in_range[c] = int'(wa[c]) < ROW_NUM;
            wr_legal[c] = row_wr_en[c] && !start && (state == S_COLLECT) &&
                          in_range[c] && !fill[wa[c]][c];
            wr_bad[c]   = row_wr_en[c] && !start && !wr_legal[c];
        end
    end

    always_comb begin
        out_valid    = (state == S_COLLECT) && (&fill[rd_row]);
        out_row_addr = rd_row;
        out_last     = out_valid && (rd_row == LAST_ROW);
        busy         = (state == S_COLLECT);
        done         = (state == S_DONE);
        accept       = out_valid && out_ready;
        out_data     = '0;
        for (int c = 0; c < COL_NUM; c++) begin
            out_data[c*SUM_WIDTH +: SUM_WIDTH] = mem[rd_row][c];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            rd_row <= '0;
            wr_err <= 1'b0;
            for (int r = 0; r < ROW_NUM; r++) begin
                fill[r] <= '0;
            end
        end else if (start) begin
            state  <= S_COLLECT;
            rd_row <= '0;
            wr_err <= 1'b0;
            for (int r = 0; r < ROW_NUM; r++) begin
                fill[r] <= '0;
            end
        end else begin
            case (state)
                S_COLLECT: if (accept && (rd_row == LAST_ROW)) state <= S_DONE;
                S_DONE:    state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase

            if (accept) begin
                rd_row <= (rd_row == LAST_ROW) ? '0 : rd_row + 1'b1;
            end

            if (|wr_bad) begin
                wr_err <= 1'b1;
            end

            // The drained row has all bits set, so no legal write can target it here.
            for (int r = 0; r < ROW_NUM; r++) begin
                for (int c = 0; c < COL_NUM; c++) begin
                    if (accept && (rd_row == ROW_ADDR_WIDTH'(r))) begin
                        fill[r][c] <= 1'b0;
                    end else if (wr_legal[c] && (wa[c] == ROW_ADDR_WIDTH'(r))) begin
                        fill[r][c] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < COL_NUM; c++) begin
            if (wr_legal[c]) begin
                mem[wa[c]][c] <= row_data_in[c*SUM_WIDTH +: SUM_WIDTH];
            end
        end
    end

endmodule
